// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between a sweep master and dds_sweep_ctrl.
// The master modport drives the sweep request and config; the slave modport drives the DDS-facing outputs.
interface dds_sweep_ctrl_if #(
   parameter int M = 24,
   parameter int D = 16
);
   logic         start;
   logic         abort;
   logic         continuous;
   logic [M-1:0] f_start;
   logic [M-1:0] f_stop;
   logic [M-1:0] f_step;
   logic [D-1:0] dwell;
   logic [M-1:0] P;
   logic         ena_ac;
   logic         val_out;
   logic         step_tick;
   logic         busy;
   logic         done;

   modport master (
      output start, abort, continuous, f_start, f_stop, f_step, dwell,
      input  P, ena_ac, val_out, step_tick, busy, done
   );

   modport slave (
      input  start, abort, continuous, f_start, f_stop, f_step, dwell,
      output P, ena_ac, val_out, step_tick, busy, done
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Chirp sequencer: steps the DDS phase increment from f_start toward f_stop, holding each value dwell+1 clocks.
// SWEEP_PINGPONG_EN: continuous sweeps reverse direction at the limit instead of reloading f_start.
module dds_sweep_ctrl #(
   parameter int M = 24,
   parameter int D = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   dds_sweep_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t       r_state;
   logic [M-1:0] r_p;
   logic [M-1:0] r_start;
   logic [M-1:0] r_stop;
   logic [M-1:0] r_step;
   logic [D-1:0] r_dwell;
   logic [D-1:0] r_cnt;
   logic         r_down;
   logic         r_cont;
   logic         r_ena;
   logic         r_val;
   logic         r_tick;
   logic         r_busy;
   logic         r_done;

   logic [M:0]   w_next;
   logic         w_end;

   // The extra MSB carries the overflow/borrow so a step past the numeric range ends the sweep
   always_comb begin
      w_next = r_down ? ({1'b0, r_p} - {1'b0, r_step}) : ({1'b0, r_p} + {1'b0, r_step});
      if (r_step == '0)
         w_end = 1'b0;
      else if (r_down)
         w_end = w_next[M] | (w_next[M-1:0] < r_stop);
      else
         w_end = w_next[M] | (w_next[M-1:0] > r_stop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_p     <= '0;
         r_start <= '0;
         r_stop  <= '0;
         r_step  <= '0;
         r_dwell <= '0;
         r_cnt   <= '0;
         r_down  <= 1'b0;
         r_cont  <= 1'b0;
         r_ena   <= 1'b0;
         r_val   <= 1'b0;
         r_tick  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_done <= 1'b0;
         if (bus.abort) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_ena   <= 1'b0;
            r_val   <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     r_start <= bus.f_start;
                     r_stop  <= bus.f_stop;
                     r_step  <= bus.f_step;
                     r_dwell <= bus.dwell;
                     r_cont  <= bus.continuous;
                     r_down  <= (bus.f_stop < bus.f_start);
                     r_p     <= bus.f_start;
                     r_cnt   <= bus.dwell;
                     r_ena   <= 1'b1;
                     r_val   <= 1'b1;
                     r_busy  <= 1'b1;
                     r_tick  <= 1'b1;
                     r_state <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - 1'b1;
                  end else if (!w_end) begin
                     r_p    <= w_next[M-1:0];
                     r_cnt  <= r_dwell;
                     r_tick <= 1'b1;
                  end else if (r_cont) begin
`ifdef SWEEP_PINGPONG_EN
                     // P stays on the last value; the swapped limits drive the return leg
                     r_down  <= ~r_down;
                     r_start <= r_stop;
                     r_stop  <= r_start;
`else
                     r_p     <= r_start;
`endif
                     r_cnt  <= r_dwell;
                     r_tick <= 1'b1;
                  end else begin
                     r_p     <= '0;
                     r_ena   <= 1'b0;
                     r_val   <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end
               end
               S_FIN:   r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.P         = r_p;
   assign bus.ena_ac    = r_ena;
   assign bus.val_out   = r_val;
   assign bus.step_tick = r_tick;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweeps plus randomized configs against a frequency-list reference model.
// The model lists the sweep frequencies arithmetically and expands them into an expected per-cycle output stream.
module tb_dds_sweep_ctrl;
   localparam int M = 24;
   localparam int D = 16;
   localparam longint MAXV = (64'd1 << M) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dds_sweep_ctrl_if #(.M(M), .D(D)) bus ();
   dds_sweep_ctrl #(.M(M), .D(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk = 0;
   int n_err = 0;

   // fl = {ena_ac, val_out, step_tick, busy, done}
   typedef struct {
      longint     p;
      logic [4:0] fl;
   } exp_t;

   exp_t   exp_q[$];
   longint seg[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input exp_t e);
      check({tag, "_P"}, 64'(bus.P), e.p);
      check({tag, "_flags"}, 64'({bus.ena_ac, bus.val_out, bus.step_tick, bus.busy, bus.done}), 64'(e.fl));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input longint p, input logic [4:0] fl);
      exp_t e;
      e.p  = p;
      e.fl = fl;
      return e;
   endfunction

   // Frequencies visited by one leg of the sweep, never passing the stop limit
   function automatic void build_seg(input longint fs, input longint fe, input longint st);
      seg.delete();
      if (st == 0) seg.push_back(fs);
      else if (fe < fs) for (longint f = fs; f >= fe; f -= st) seg.push_back(f);
      else              for (longint f = fs; f <= fe && f <= MAXV; f += st) seg.push_back(f);
   endfunction

   function automatic void push_hold(input longint f, input int dw);
      for (int d = 0; d <= dw; d++) exp_q.push_back(mk(f, {3'b110 | 3'(d == 0), 2'b10}));
   endfunction

   function automatic void gen(input longint fs, input longint fe, input longint st, input int dw,
                               input bit cont, input int ncyc);
      bit rev = 0;
      exp_q.delete();
      build_seg(fs, fe, st);
      if (!cont && st != 0) begin
         foreach (seg[k]) push_hold(seg[k], dw);
         exp_q.push_back(mk(0, 5'b00001));
         exp_q.push_back(mk(0, 5'b00000));
         exp_q.push_back(mk(0, 5'b00000));
      end else begin
         while (exp_q.size() < ncyc) begin
            for (int k = 0; k < seg.size(); k++) push_hold(rev ? seg[seg.size()-1-k] : seg[k], dw);
`ifdef SWEEP_PINGPONG_EN
            rev = ~rev;
`endif
         end
         while (exp_q.size() > ncyc) void'(exp_q.pop_back());
      end
   endfunction

   task automatic scramble_cfg();
      bus.continuous = 1'($urandom);
      bus.f_start    = M'($urandom);
      bus.f_stop     = M'($urandom);
      bus.f_step     = M'($urandom);
      bus.dwell      = D'($urandom);
   endtask

   // Runs one sweep; abort_at = index of the entry the abort edge would have produced (-1: none)
   task automatic run_sweep(input string tag, input longint fs, input longint fe, input longint st,
                            input int dw, input bit cont, input int ncyc, input int abort_at);
      gen(fs, fe, st, dw, cont, ncyc);
      bus.f_start = M'(fs); bus.f_stop = M'(fe); bus.f_step = M'(st);
      bus.dwell = D'(dw); bus.continuous = cont;
      bus.start = 1'b1; bus.abort = 1'b0;
      step();
      for (int i = 0; i < exp_q.size(); i++) begin
         check_out(tag, exp_q[i]);
         scramble_cfg();
         bus.start = (exp_q[i].fl != 5'b0) ? 1'($urandom) : 1'b0;
         if (abort_at == i + 1 || (i == exp_q.size() - 1 && abort_at >= 0)) begin
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            bus.start = 1'b0;
            check_out({tag, "_abort"}, mk(0, 5'b0));
            step();
            check_out({tag, "_after_abort"}, mk(0, 5'b0));
            return;
         end
         if (i == exp_q.size() - 1) break;
         step();
      end
      bus.start = 1'b0;
   endtask

   initial begin
      longint fs, fe, st;
      int dw, n, ncyc, ab;
      bit cont;
      bus.start = 1'b0; bus.abort = 1'b0; bus.continuous = 1'b0;
      bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;
      #1;
      check_out("reset", mk(0, 5'b0));
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_out("idle", mk(0, 5'b0));

      run_sweep("up_single", 100, 130, 10, 2, 0, 0, -1);
      run_sweep("down_overshoot", 50, 15, 20, 0, 0, 0, -1);
      run_sweep("wrap_guard", 64'hFFFFF0, 64'hFFFFFF, 8, 0, 0, 0, -1);
      run_sweep("equal_limits", 777, 777, 5, 3, 0, 0, -1);
      run_sweep("continuous", 100, 120, 10, 0, 1, 14, 14);
      run_sweep("tone", 4242, 9000, 0, 1, 0, 12, 12);
      run_sweep("single_abort", 100, 200, 10, 1, 0, 0, 5);

      bus.f_start = 24'd100; bus.f_stop = 24'd120; bus.f_step = 24'd10; bus.dwell = '0;
      bus.start = 1'b1; bus.abort = 1'b1;
      step();
      check_out("start_abort", mk(0, 5'b0));
      bus.start = 1'b0; bus.abort = 1'b0;
      step();
      check_out("start_abort_idle", mk(0, 5'b0));

      for (int t = 0; t < 40; t++) begin
         dw   = $urandom_range(0, 3);
         st   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
         n    = $urandom_range(0, 5);
         cont = 1'($urandom);
         case ($urandom_range(0, 3))
            0: begin fs = $urandom_range(0, 1 << 22); fe = fs + n * st + $urandom_range(0, 39); end
            1: begin fs = (1 << 23) + $urandom_range(0, 1 << 22); fe = fs - n * st - $urandom_range(0, 39); end
            2: begin fs = MAXV - $urandom_range(0, 60); fe = MAXV; end
            default: begin fs = $urandom_range(0, 60); fe = 0; end
         endcase
         if (fe < 0) fe = 0;
         if (fe > MAXV) fe = MAXV;
         ncyc = $urandom_range(4, 40);
         if (cont || st == 0) ab = ncyc;
         else ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : -1;
         run_sweep($sformatf("rand%0d", t), fs, fe, st, dw, cont, ncyc, ab);
      end

      bus.f_start = 24'd100; bus.f_stop = 24'd130; bus.f_step = 24'd10; bus.dwell = 16'd2;
      bus.continuous = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", mk(0, 5'b0));
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_out("post_reset_idle", mk(0, 5'b0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
